apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator that converts a single-request valid/ready command port into APB SETUP/ACCESS transfers.
- Drives the APB interconnect's master side: addr_in, wr_in, sel, en_in and data_in. Consumes the interconnect's ready_out, readdata and PSLVERR.
- Returns one response per request and enforces a wait-state timeout so that a hung slave cannot stall the core.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  bridge can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  command address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  PSLVERR or timeout.
- paddr  out  ADDR_W  APB address, to interconnect addr_in.
- pwrite  out  1  APB direction, to wr_in.
- pwdata  out  DATA_W  APB write data, to data_in.
- psel  out  1  APB select, to sel.
- penable  out  1  APB enable, to en_in.
- pready  in  1  from interconnect ready_out.
- prdata  in  DATA_W  from interconnect readdata.
- pslverr  in  1  from interconnect PSLVERR.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except req_ready=1. Timeout counter=0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1, psel=0, penable=0.
  - On req_valid&&req_ready, capture req_addr/req_write/req_wdata into paddr/pwrite/pwdata and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, req_ready=0.
  - Go to ACCESS.
- ACCESS:
  - psel=1, penable=1, req_ready=0.
  - paddr/pwrite/pwdata held stable from SETUP through the end of ACCESS.
  - If pready=1: transfer completes this cycle and state goes to IDLE.
  - On completion, in the next cycle: rsp_valid=1, rsp_err=pslverr (sampled at completion), rsp_rdata = (!pwrite && !pslverr) ? prdata : 0.
  - If pready=0: counter increments.
- Timeout: TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 with pready=0.
  - Abort; go to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - psel and penable drop to 0 on the abort edge.
- Counter clears on entry to SETUP.
- Latency with zero wait states:
  - Accept edge → SETUP (cycle 1) → ACCESS (cycle 2) → rsp_valid in cycle 3.
  - Each PREADY-low cycle adds 1.
- Throughput:
  - req_ready=1 in the same cycle as rsp_valid, so a new command may be accepted then.
  - Minimum spacing is 3 cycles per transfer.
- Responses have no backpressure; rsp_valid is a 1-cycle pulse. rsp_rdata and rsp_err hold their value until the next response.
- paddr/pwrite/pwdata hold their last value in IDLE; they are not zeroed.
- req_valid while req_ready=0 is ignored and not latched.
- pready and pslverr are ignored outside ACCESS.
- Reset mid-transfer: psel and penable go to 0 immediately (asynchronous). No response is generated.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e.
  - APB_ADDR_W=12, APB_DATA_W=32 constants.
  - typedef struct apb_req_t {write, addr, wdata}.
- Sub-module apb_timeout_ctr:
  - Inputs: clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT_CYCLES.
  - Tied off to expired=0 when TIMEOUT_CYCLES=0.
- All other logic (FSM, capture registers, response register) lives in apb_master_bridge.

Test Plan:
- Write, zero wait:
  - Stimulus: req addr=0x104, wdata=0xDEADBEEF, pready=1.
  - Required: SETUP cycle psel=1/penable=0, ACCESS cycle psel=1/penable=1 with paddr=0x104 and pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states:
  - Stimulus: addr=0x2A0, pready low 3 cycles then high, prdata=0x12345678.
  - Required: ACCESS lasts 4 cycles with paddr stable; rsp_rdata=0x12345678 at cycle 6.
- Slave error:
  - Stimulus: read with pready=1, pslverr=1, prdata=0xFFFF0000.
  - Required: rsp_err=1, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, pready held 0.
  - Required: exactly 4 ACCESS cycles, then psel=0; rsp_valid with rsp_err=1; next request accepted normally.
- Back-to-back:
  - Stimulus: req_valid held high with 3 queued commands to 0x100, 0x200, 0x300.
  - Required: accepts in cycles 0/3/6; psel deasserts for exactly 1 cycle (IDLE) between transfers; responses in order.
- Reset mid-ACCESS:
  - Stimulus: rst=0 while penable=1.
  - Required: psel, penable and req_ready go to 0/0/1 without a clock edge; no rsp_valid after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB bridge types: FSM state encoding, default bus widths and the command bundle.
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles; expired is combinational on the last permitted wait cycle.
// No backpressure; TIMEOUT_CYCLES=0 ties expired low.
module apb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturates at LAST: the abort fires there, so the count never needs to wrap.
      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB SETUP/ACCESS initiator; response 3 cycles after accept plus wait states.
// req_ready low while a transfer is in flight; responses are unbackpressured 1-cycle pulses.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  apb_state_e        state_q;
  logic              req_ready_q, psel_q, penable_q, pwrite_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              accept, wait_cycle, to_expired;

  assign accept     = req_valid && req_ready_q;
  assign wait_cycle = (state_q == ACCESS) && !pready;

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (wait_cycle),
    .expired(to_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            paddr_q     <= req_addr;
            pwrite_q    <= req_write;
            pwdata_q    <= req_wdata;
            psel_q      <= 1'b1;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // Completion and timeout abort share one exit; an abort is reported as an error.
          if (pready || to_expired) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !pready || pslverr;
            rsp_rdata_q <= (pready && !pwrite_q && !pslverr) ? prdata : '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboarded bench: stimulus pushes model responses, an APB slave model and a response monitor check.
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          psel;
  logic          penable;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    apb_req_t      req;
    int            waits;
    bit            err;
    logic [DW-1:0] rdata;
  } plan_t;

  typedef struct {
    int            cyc;
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: accept in cycle acc; response in acc+3+waits, or acc+2+TO when the slave stalls too long.
  function automatic exp_t model(input plan_t p, input int acc);
    exp_t e;
    if (p.waits >= TO) begin
      e.cyc = acc + 2 + TO; e.err = 1'b1; e.rdata = '0;
    end else begin
      e.cyc = acc + 3 + p.waits; e.err = p.err;
      e.rdata = (p.req.write || p.err) ? '0 : p.rdata;
    end
    return e;
  endfunction

  function automatic int access_len(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int waits, input bit err, input logic [DW-1:0] rd);
    plan_t p;
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    p.req.write = wr; p.req.addr = a; p.req.wdata = wd;
    p.waits = waits; p.err = err; p.rdata = rd;
    plan_q.push_back(p);
    exp_q.push_back(model(p, cyc));
    last_acc = cyc;
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // APB slave model: answers each transfer from its plan and checks bus stability.
  bit    active = 1'b0;
  int    wcnt = 0;
  int    acnt = 0;
  plan_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      plan_q.delete();
      active = 1'b0;
      pready = 1'b0;
    end else if (psel && penable) begin
      if (!active && plan_q.size() == 0) begin
        check("access_without_request", 1, 0);
      end else begin
        if (!active) begin
          cur = plan_q.pop_front();
          active = 1'b1; wcnt = 0; acnt = 0;
        end
        acnt++;
        check("access_paddr", paddr, cur.req.addr);
        check("access_pwrite", pwrite, cur.req.write);
        check("access_pwdata", pwdata, cur.req.wdata);
        if (wcnt < cur.waits) begin
          pready = 1'b0; wcnt++;
          pslverr = 1'($urandom); prdata = $urandom;
        end else begin
          pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
        end
      end
    end else begin
      if (active) begin
        check("access_length", acnt, access_len(cur.waits));
        active = 1'b0;
      end
      if (psel) begin
        if (plan_q.size() == 0) check("setup_without_request", 1, 0);
        else begin
          check("setup_paddr", paddr, plan_q[0].req.addr);
          check("setup_pwdata", pwdata, plan_q[0].req.wdata);
        end
      end
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    end
  end

  // Response monitor: pops the scoreboard on every pulse, checks held values otherwise.
  logic [DW-1:0] last_rdata = '0;
  bit            last_err = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      last_rdata = '0; last_err = 1'b0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_err", rsp_err, e.err);
        check("rsp_rdata", rsp_rdata, e.rdata);
        last_rdata = e.rdata; last_err = e.err;
      end
    end else begin
      check("rsp_hold_err", rsp_err, last_err);
      check("rsp_hold_rdata", rsp_rdata, last_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, w, gap;
    #12;
    check("reset_req_ready", req_ready, 1);
    check("reset_psel", psel, 0);
    check("reset_penable", penable, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    @(negedge clk); #2 rst = 1'b1;

    issue(1'b1, 12'h104, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    drain();
    issue(1'b0, 12'h2A0, 32'h0BAD_F00D, 3, 1'b0, 32'h12345678);
    drain();
    issue(1'b0, 12'h3F0, 32'h0, 0, 1'b1, 32'hFFFF0000);
    drain();
    issue(1'b0, 12'h7C4, 32'h0, 100, 1'b0, 32'hCAFEF00D);
    drain();
    check("post_timeout_psel", psel, 0);
    issue(1'b0, 12'h7C8, 32'h0, 1, 1'b0, 32'h600DCAFE);
    drain();

    issue(1'b0, 12'h100, 32'h1, 0, 1'b0, 32'hAAAA0100); a0 = last_acc;
    issue(1'b0, 12'h200, 32'h2, 0, 1'b0, 32'hAAAA0200); a1 = last_acc;
    issue(1'b0, 12'h300, 32'h3, 0, 1'b0, 32'hAAAA0300); a2 = last_acc;
    drain();
    check("b2b_spacing_1", a1 - a0, 3);
    check("b2b_spacing_2", a2 - a1, 3);

    issue(1'b1, 12'h3C0, 32'hA5A50F0F, 3, 1'b0, 32'h0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("mid_access_penable", penable, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_psel", psel, 0);
    check("async_rst_penable", penable, 0);
    check("async_rst_req_ready", req_ready, 1);
    check("async_rst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
      issue(1'($urandom), AW'($urandom), $urandom, w, ($urandom_range(0, 3) == 0), $urandom);
      gap = $urandom_range(0, 2);
      if (gap == 0) drain();
    end
    drain();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
